// File: rtl/conv_ag_pkg.sv
// Shared types and defaults for the convolution address generator.
package conv_ag_pkg;

    localparam int KMAX_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RUN,
        FIN
    } state_e;

endpackage

// File: rtl/conv_ag_cnt.sv
// Loadable wrap counter; carry fires when enabled at its limit.
module conv_ag_cnt
    import conv_ag_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         en_i,
    input  logic [W-1:0] lim_i,
    output logic         last_o,
    output logic         co_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == lim_i);
    assign co_o   = en_i && last_o;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_addr_gen.sv
// Convolution activation address generator (oy, ox, c, ky, kx order).
module conv_addr_gen
    import conv_ag_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int KMAX   = KMAX_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_c,
    input  logic [2:0]        cfg_k,
    input  logic [1:0]        cfg_s,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              win_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PW = ((3 * DIM_W > ADDR_W) ? 3 * DIM_W : ADDR_W) + 1;

    typedef logic [DIM_W-1:0]  dim_t;
    typedef logic [ADDR_W-1:0] addr_t;

    state_e state_q, state_d;
    dim_t   w_q, h_q, c_q, w_d, h_d, c_d;
    logic [2:0] k_q, k_d;
    logic [1:0] s_q, s_d;
    dim_t   lox_q, loy_q, lox_d, loy_d;
    addr_t  wh_q, sw_q, wh_d, sw_d;
    addr_t  addr_q, row_q, ch_q, win_q, orow_q;
    addr_t  addr_d, row_d, ch_d, win_d, orow_d;
    logic   err_q, err_d;

    logic    illegal, xfer, ld;
    logic [PW-1:0] vol;
    dim_t    kd, klim, clim;
    logic    kx_last, ky_last, c_last, ox_last, oy_last;
    logic    kx_co, ky_co, c_co, ox_co, oy_co;

    assign kd   = dim_t'(k_q);
    assign klim = kd - 1'b1;
    assign clim = c_q - 1'b1;
    assign vol  = PW'(c_q) * PW'(w_q) * PW'(h_q);

    assign illegal = (k_q == 3'd0) || (32'(k_q) > KMAX) ||
                     (s_q == 2'd0) || (kd > w_q) || (kd > h_q) ||
                     (c_q == '0) || (vol > (PW'(1) << ADDR_W));

    assign addr_valid = (state_q == RUN);
    assign busy       = (state_q == CHECK) || (state_q == RUN);
    assign done       = (state_q == FIN);
    assign err        = err_q;
    assign addr_out   = addr_q;
    assign win_last   = addr_valid && kx_last && ky_last && c_last;
    assign xfer       = addr_valid && addr_ready && !abort;
    assign ld         = (state_q == CHECK);

    conv_ag_cnt #(.W(DIM_W)) u_kx (
        .clk(clk), .rstn(rstn), .ld_i(ld), .ld_val_i('0),
        .en_i(xfer), .lim_i(klim), .last_o(kx_last), .co_o(kx_co));
    conv_ag_cnt #(.W(DIM_W)) u_ky (
        .clk(clk), .rstn(rstn), .ld_i(ld), .ld_val_i('0),
        .en_i(kx_co), .lim_i(klim), .last_o(ky_last), .co_o(ky_co));
    conv_ag_cnt #(.W(DIM_W)) u_c (
        .clk(clk), .rstn(rstn), .ld_i(ld), .ld_val_i('0),
        .en_i(ky_co), .lim_i(clim), .last_o(c_last), .co_o(c_co));
    conv_ag_cnt #(.W(DIM_W)) u_ox (
        .clk(clk), .rstn(rstn), .ld_i(ld), .ld_val_i('0),
        .en_i(c_co), .lim_i(lox_q), .last_o(ox_last), .co_o(ox_co));
    conv_ag_cnt #(.W(DIM_W)) u_oy (
        .clk(clk), .rstn(rstn), .ld_i(ld), .ld_val_i('0),
        .en_i(ox_co), .lim_i(loy_q), .last_o(oy_last), .co_o(oy_co));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = illegal ? FIN : RUN;
            RUN:     if (oy_co) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Multiplies and divides here run only in CHECK, never per address.
    always_comb begin
        w_d   = w_q;
        h_d   = h_q;
        c_d   = c_q;
        k_d   = k_q;
        s_d   = s_q;
        err_d = err_q;
        lox_d = lox_q;
        loy_d = loy_q;
        wh_d  = wh_q;
        sw_d  = sw_q;
        if (state_q == IDLE && start && !abort) begin
            w_d   = cfg_w;
            h_d   = cfg_h;
            c_d   = cfg_c;
            k_d   = cfg_k;
            s_d   = cfg_s;
            err_d = 1'b0;
        end
        if (state_q == CHECK && !abort) begin
            err_d = illegal;
            if (!illegal) begin
                lox_d = (w_q - kd) / dim_t'(s_q);
                loy_d = (h_q - kd) / dim_t'(s_q);
                wh_d  = addr_t'(PW'(w_q) * PW'(h_q));
                sw_d  = addr_t'(PW'(s_q) * PW'(w_q));
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        row_d  = row_q;
        ch_d   = ch_q;
        win_d  = win_q;
        orow_d = orow_q;
        if (state_q == CHECK) begin
            addr_d = '0;
            row_d  = '0;
            ch_d   = '0;
            win_d  = '0;
            orow_d = '0;
        end else if (xfer) begin
            if (!kx_last) begin
                addr_d = addr_q + 1'b1;
            end else if (!ky_last) begin
                row_d  = row_q + addr_t'(w_q);
                addr_d = row_d;
            end else if (!c_last) begin
                ch_d   = ch_q + wh_q;
                row_d  = ch_d;
                addr_d = ch_d;
            end else if (!ox_last) begin
                win_d  = win_q + addr_t'(s_q);
                ch_d   = win_d;
                row_d  = win_d;
                addr_d = win_d;
            end else begin
                orow_d = orow_q + sw_q;
                win_d  = orow_d;
                ch_d   = orow_d;
                row_d  = orow_d;
                addr_d = orow_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            s_q     <= '0;
            err_q   <= 1'b0;
            lox_q   <= '0;
            loy_q   <= '0;
            wh_q    <= '0;
            sw_q    <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            win_q   <= '0;
            orow_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            c_q     <= c_d;
            k_q     <= k_d;
            s_q     <= s_d;
            err_q   <= err_d;
            lox_q   <= lox_d;
            loy_q   <= loy_d;
            wh_q    <= wh_d;
            sw_q    <= sw_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            win_q   <= win_d;
            orow_q  <= orow_d;
        end
    end

endmodule

// File: tb/tb_conv_addr_gen.sv
// Directed bench for conv_addr_gen with a formula-based address model.
module tb_conv_addr_gen;

    logic        clk = 1'b0;
    logic        rstn, start, abort, addr_ready;
    logic [7:0]  cfg_w, cfg_h, cfg_c;
    logic [2:0]  cfg_k;
    logic [1:0]  cfg_s;
    logic [15:0] addr_out;
    logic        addr_valid, win_last, busy, done, err;

    int checks = 0;
    int errors = 0;
    int exp_a[$];
    bit exp_l[$];
    int got_a[$];
    int win0[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int k1seq[12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};

    always #5 clk = ~clk;

    conv_addr_gen dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_c(cfg_c),
        .cfg_k(cfg_k), .cfg_s(cfg_s),
        .addr_out(addr_out), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .win_last(win_last),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_layer(input string tag, input int w, input int h,
                             input int c, input int k, input int s,
                             input bit stall, input int cut,
                             input bit use_rst);
        int ow, oh, idx, rc;
        exp_a.delete();
        exp_l.delete();
        got_a.delete();
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ch = 0; ch < c; ch++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            exp_a.push_back(ch * w * h + (oy * s + ky) * w
                                            + ox * s + kx);
                            exp_l.push_back(ch == c - 1 && ky == k - 1 &&
                                            kx == k - 1);
                        end
        cfg_w = 8'(w);
        cfg_h = 8'(h);
        cfg_c = 8'(c);
        cfg_k = 3'(k);
        cfg_s = 2'(s);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_w = 8'hff;
        cfg_h = 8'h01;
        cfg_c = 8'h00;
        cfg_k = 3'd7;
        cfg_s = 2'd0;
        chk({tag, "/chk_busy"}, busy, 1);
        chk({tag, "/chk_valid"}, addr_valid, 0);
        chk({tag, "/chk_err"}, err, 0);
        tick();
        idx = 0;
        rc = 1;
        while (idx < exp_a.size() && rc < 1000) begin
            addr_ready = !(stall && rc >= 3 && rc <= 5);
            start = (rc == 4);
            chk({tag, "/valid"}, addr_valid, 1);
            chk({tag, "/addr"}, addr_out, exp_a[idx]);
            chk({tag, "/last"}, win_last, exp_l[idx]);
            if (addr_ready) begin
                got_a.push_back(int'(addr_out));
                idx++;
            end
            tick();
            rc++;
            if (cut != 0 && idx == cut) break;
        end
        start = 1'b0;
        addr_ready = 1'b1;
        if (cut == 0) begin
            chk({tag, "/xfers"}, idx, exp_a.size());
            chk({tag, "/done"}, done, 1);
            chk({tag, "/busy_fin"}, busy, 0);
            chk({tag, "/valid_fin"}, addr_valid, 0);
            chk({tag, "/err_fin"}, err, 0);
            tick();
            chk({tag, "/done_clr"}, done, 0);
        end else if (!use_rst) begin
            chk({tag, "/cut_xfers"}, idx, cut);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk({tag, "/abort_valid"}, addr_valid, 0);
            chk({tag, "/abort_busy"}, busy, 0);
            chk({tag, "/abort_done"}, done, 0);
            repeat (3) begin
                tick();
                chk({tag, "/abort_nodone"}, done, 0);
            end
        end else begin
            chk({tag, "/cut_xfers"}, idx, cut);
            rstn = 1'b0;
            #1;
            chk({tag, "/rst_valid"}, addr_valid, 0);
            chk({tag, "/rst_busy"}, busy, 0);
            chk({tag, "/rst_addr"}, addr_out, 0);
            chk({tag, "/rst_last"}, win_last, 0);
            chk({tag, "/rst_done"}, done, 0);
            tick();
            rstn = 1'b1;
            repeat (3) begin
                tick();
                chk({tag, "/rst_idle_busy"}, busy, 0);
                chk({tag, "/rst_idle_done"}, done, 0);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        addr_ready = 1'b1;
        cfg_w = '0;
        cfg_h = '0;
        cfg_c = '0;
        cfg_k = '0;
        cfg_s = '0;
        repeat (2) tick();
        chk("reset/addr", addr_out, 0);
        chk("reset/valid", addr_valid, 0);
        chk("reset/last", win_last, 0);
        chk("reset/busy", busy, 0);
        chk("reset/done", done, 0);
        chk("reset/err", err, 0);
        rstn = 1'b1;
        tick();

        run_layer("basic", 4, 4, 1, 3, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) chk("basic/win0", got_a[i], win0[i]);
        chk("basic/win1_start", got_a[9], 1);
        chk("basic/count", got_a.size(), 36);

        run_layer("stall", 4, 4, 1, 3, 1, 1, 0, 0);
        chk("stall/count", got_a.size(), 36);
        chk("stall/win1_start", got_a[9], 1);

        run_layer("s2c2", 5, 5, 2, 3, 2, 0, 0, 0);
        chk("s2c2/count", got_a.size(), 72);
        chk("s2c2/ch1_start", got_a[9], 25);
        chk("s2c2/ox1_start", got_a[18], 2);

        cfg_w = 8'd3;
        cfg_h = 8'd8;
        cfg_c = 8'd1;
        cfg_k = 3'd4;
        cfg_s = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("illegal/chk_valid", addr_valid, 0);
        chk("illegal/chk_busy", busy, 1);
        tick();
        chk("illegal/done", done, 1);
        chk("illegal/err", err, 1);
        chk("illegal/valid", addr_valid, 0);
        tick();
        chk("illegal/done_clr", done, 0);
        chk("illegal/err_held", err, 1);
        chk("illegal/valid_idle", addr_valid, 0);

        run_layer("abort", 4, 4, 1, 3, 1, 0, 10, 0);
        run_layer("post_abort", 4, 4, 1, 3, 1, 0, 0, 0);
        run_layer("rst_mid", 4, 4, 1, 3, 1, 0, 10, 1);
        run_layer("post_rst", 4, 4, 1, 3, 1, 0, 0, 0);

        run_layer("k1", 2, 2, 3, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) chk("k1/seq", got_a[i], k1seq[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_addr_gen.md
CONV_ADDR_GEN -- requirements
Module: conv_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 16: activation-memory address width.
REQ-002 Parameter DIM_W, default 8: width of width, height and channel configuration fields.
REQ-003 Parameter KMAX, default 5: largest supported square kernel size.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a layer; honoured only in IDLE.
REQ-007 abort  in  1  synchronous cancel; returns to IDLE next cycle.
REQ-008 cfg_w, cfg_h, cfg_c  in  DIM_W each  input width, height and channel count.
REQ-009 cfg_k  in  3  kernel size; cfg_s  in  2  stride.
REQ-010 addr_out  out  ADDR_W  activation address.
REQ-011 addr_valid  out  1 / addr_ready  in  1  valid/ready handshake; transfer occurs when both are high.
REQ-012 win_last  out  1  qualifies the last address of each window.
REQ-013 busy  out  1 / done  out  1 / err  out  1  status outputs.

Function
REQ-014 States: IDLE, CHECK, RUN, FIN.
  - IDLE -> CHECK on start; config latched on the same edge.
  - CHECK -> RUN if config legal, else -> FIN with err set.
  - RUN -> FIN on acceptance of the final address.
  - FIN -> IDLE after one cycle.
REQ-015 Config is illegal if any of the following holds:
  - cfg_k == 0 or cfg_k > KMAX;
  - cfg_s == 0;
  - cfg_k > cfg_w or cfg_k > cfg_h;
  - cfg_c == 0;
  - cfg_c*cfg_w*cfg_h > 2^ADDR_W.
REQ-016 Output grid: OW = (W-K)/S+1, OH = (H-K)/S+1, using integer division.
REQ-017 Emission order, from outermost to innermost loop: oy, ox, c, ky, kx.
REQ-018 Address = c*W*H + (oy*S+ky)*W + ox*S + kx.
  - Computed incrementally from base registers; no run-time multipliers in the per-address path.
REQ-019 addr_valid is high only in RUN; the first address is valid in the cycle after CHECK (2 cycles after start).
REQ-020 While addr_valid && !addr_ready, addr_out and win_last are held stable.
REQ-021 Counters advance only on a transfer; one address per cycle is sustained while addr_ready stays high.
REQ-022 win_last is high with the (K*K*C)-th address of every window.
REQ-023 Total addresses emitted per layer = OW*OH*K*K*C.
REQ-024 done is a one-cycle pulse in FIN; err is valid in that cycle and is held until the next start.
REQ-025 busy is high in CHECK and RUN.
REQ-026 start outside IDLE is ignored.
REQ-027 Config input changes outside IDLE have no effect.
REQ-028 abort takes priority over start and over transfers: the next cycle is IDLE, addr_valid is 0, and no done pulse is issued.

Reset
REQ-029 While rstn is low, all of the following take effect immediately:
  - state = IDLE;
  - addr_out = 0, addr_valid = 0, win_last = 0;
  - busy = 0, done = 0, err = 0;
  - all counters and base registers = 0.
REQ-030 Reset asserted mid-RUN discards the layer; after release, the block waits for a new start.

Structure
REQ-031 Shared package conv_ag_pkg holds the state enum and the KMAX default.
REQ-032 Sub-module conv_ag_cnt: loadable wrap counter with enable, limit input and carry-out; instantiated per loop level (kx, ky, c, ox, oy).

Verification
REQ-033 Basic 3x3 window:
  - Stimulus: W=H=4, C=1, K=3, S=1, ready tied high.
  - Response: 36 addresses; first window 0,1,2,4,5,6,8,9,10 with win_last on 10; second window starts at 1; done pulse one cycle after the 36th transfer.
REQ-034 Backpressure:
  - Stimulus: same config as REQ-033; addr_ready low for cycles 3-5 of RUN.
  - Response: addr_out stable over the stall; sequence identical to REQ-033; 36 transfers total.
REQ-035 Stride 2, two channels:
  - Stimulus: W=H=5, C=2, K=3, S=2.
  - Response: 72 addresses; window (oy=0, ox=1) starts at 2; channel 1 of window 0 starts at 25.
REQ-036 Illegal config:
  - Stimulus: K=4, W=3.
  - Response: addr_valid never asserts; done=1 and err=1 exactly 2 cycles after start.
REQ-037 Abort and reset mid-run:
  - Stimulus: abort after 10 transfers.
  - Response: addr_valid=0 and busy=0 next cycle; no done pulse; next start restarts at address 0.
  - Repeat with rstn pulled low mid-RUN: the same response is required.
REQ-038 1x1 kernel:
  - Stimulus: K=1, S=1, W=H=2, C=3.
  - Response: 12 addresses in the order 0,4,8,1,5,9,2,6,10,3,7,11; win_last on every third address.
